// File: rtl/zion_skid_pkg.sv
// Shared types for the clearable two-entry skid buffer.
package zion_skid_pkg;

   localparam int unsigned CNT_W = 2;

   // Occupancy state; the encoding doubles as the entry count.
   typedef enum logic [CNT_W-1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/zion_clr_en_reg.sv
// Data register with load enable and synchronous clear to INI_DATA.
module zion_clr_en_reg #(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] INI_DATA = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             iEn,
   input  logic             iClr,
   input  logic [WIDTH-1:0] iDat,
   output logic [WIDTH-1:0] oDat
);

   logic [WIDTH-1:0] dat_d;
   logic [WIDTH-1:0] dat_q;

   // Clear wins over load; iDat only sampled when loading.
   always_comb begin
      dat_d = dat_q;
      if (iClr) begin
         dat_d = INI_DATA;
      end else if (iEn) begin
         dat_d = iDat;
      end
   end

   // Storage with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dat_q <= INI_DATA;
      end else begin
         dat_q <= dat_d;
      end
   end

   assign oDat = dat_q;

endmodule

// File: rtl/zion_clr_skid_buffer.sv
// Two-entry valid/ready register slice with synchronous clear; all outputs registered.
module zion_clr_skid_buffer
   import zion_skid_pkg::*;
#(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] INI_DATA = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             iClr,
   input  logic             iVld,
   output logic             oRdy,
   input  logic [WIDTH-1:0] iDat,
   output logic             oVld,
   input  logic             iRdy,
   output logic [WIDTH-1:0] oDat,
   output logic [CNT_W-1:0] oCnt
);

   state_t state_d;
   state_t state_q;
   logic   vld_d;
   logic   vld_q;
   logic   rdy_d;
   logic   rdy_q;

   logic   in_xfer;
   logic   out_xfer;
   logic   main_en;
   logic   skid_en;
   logic   main_from_skid;

   logic [WIDTH-1:0] main_din;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;

   // Handshakes are qualified by the registered ready/valid only.
   assign in_xfer  = iVld & rdy_q;
   assign out_xfer = vld_q & iRdy;

   // State and handshake-flag registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= EMPTY;
         vld_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         vld_q   <= vld_d;
         rdy_q   <= rdy_d;
      end
   end

   // Next-state: occupancy tracking, clear flushes to EMPTY.
   always_comb begin
      state_d = state_q;
      if (iClr) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (in_xfer) state_d = BUSY;
            BUSY: begin
               if (in_xfer && !out_xfer) begin
                  state_d = FULL;
               end else if (!in_xfer && out_xfer) begin
                  state_d = EMPTY;
               end
            end
            FULL: if (out_xfer) state_d = BUSY;
            default: state_d = EMPTY;
         endcase
      end
   end

   // Outputs: next-cycle flags and datapath load controls.
   always_comb begin
      vld_d          = (state_d != EMPTY);
      rdy_d          = (state_d != FULL);
      main_en        = 1'b0;
      skid_en        = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         EMPTY: main_en = in_xfer;
         BUSY: begin
            main_en = in_xfer & out_xfer;
            skid_en = in_xfer & ~out_xfer;
         end
         FULL: begin
            main_en        = out_xfer;
            main_from_skid = 1'b1;
         end
         default: ;
      endcase
   end

   // On drain from FULL the skid entry moves up to the head.
   assign main_din = main_from_skid ? skid_q : iDat;

   zion_clr_en_reg #(
      .WIDTH    (WIDTH),
      .INI_DATA (INI_DATA)
   ) u_main (
      .clk  (clk),
      .rst  (rst),
      .iEn  (main_en),
      .iClr (iClr),
      .iDat (main_din),
      .oDat (main_q)
   );

   zion_clr_en_reg #(
      .WIDTH    (WIDTH),
      .INI_DATA (INI_DATA)
   ) u_skid (
      .clk  (clk),
      .rst  (rst),
      .iEn  (skid_en),
      .iClr (iClr),
      .iDat (iDat),
      .oDat (skid_q)
   );

   assign oVld = vld_q;
   assign oRdy = rdy_q;
   assign oDat = main_q;
   assign oCnt = CNT_W'(state_q);

endmodule

// File: tb/tb_zion_clr_skid_buffer.sv
// Self-checking bench: directed vector table plus random stress against a FIFO scoreboard.
module tb_zion_clr_skid_buffer;

   localparam int unsigned W   = 32;
   localparam logic [W-1:0] INI = 32'h0BAD_F00D;

   logic         clk;
   logic         rst;
   logic         iClr;
   logic         iVld;
   logic         oRdy;
   logic [W-1:0] iDat;
   logic         oVld;
   logic         iRdy;
   logic [W-1:0] oDat;
   logic [1:0]   oCnt;

   zion_clr_skid_buffer #(.WIDTH(W), .INI_DATA(INI)) dut (
      .clk  (clk),
      .rst  (rst),
      .iClr (iClr),
      .iVld (iVld),
      .oRdy (oRdy),
      .iDat (iDat),
      .oVld (oVld),
      .iRdy (iRdy),
      .oDat (oDat),
      .oCnt (oCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic         r;
      logic         c;
      logic         v;
      logic         rd;
      logic [W-1:0] d;
      logic         ev;
      logic         er;
      logic [1:0]   ec;
      logic [W-1:0] ed;
   } vec_t;

   vec_t tbl[$];

   int n_cmp = 0;
   int n_err = 0;

   logic [W-1:0] sb[$];
   logic         m_rdy  = 1'b0;
   logic [W-1:0] m_last = INI;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic c, input logic v, input logic rd,
                      input logic [W-1:0] d, input logic ev, input logic er,
                      input logic [1:0] ec, input logic [W-1:0] ed);
      vec_t t;
      t = '{r: r, c: c, v: v, rd: rd, d: d, ev: ev, er: er, ec: ec, ed: ed};
      tbl.push_back(t);
   endtask

   // One clock: drive, check the departing beat, update the scoreboard, check outputs.
   task automatic step(input logic r, input logic c, input logic v, input logic rd,
                       input logic [W-1:0] d);
      logic         m_vld;
      logic         in_x;
      logic         out_x;
      logic         stab;
      logic [W-1:0] pv_dat;
      logic [W-1:0] exp_dat;
      rst = r; iClr = c; iVld = v; iRdy = rd; iDat = d;
      m_vld = (sb.size() > 0);
      in_x  = v & m_rdy;
      out_x = m_vld & rd;
      stab  = r & ~c & m_vld & ~rd;
      pv_dat = oDat;
      if (out_x) begin
         exp_dat = sb[0];
         chk("out_beat", oDat, exp_dat);
      end
      @(posedge clk);
      if (!r) begin
         sb.delete();
         m_rdy  = 1'b0;
         m_last = INI;
      end else if (c) begin
         sb.delete();
         m_rdy  = 1'b1;
         m_last = INI;
      end else begin
         if (out_x) void'(sb.pop_front());
         if (in_x) sb.push_back(d);
         m_rdy = (sb.size() < 2);
         if (sb.size() > 0) m_last = sb[0];
      end
      #1;
      chk("model_oVld", W'(oVld), W'(sb.size() > 0));
      chk("model_oRdy", W'(oRdy), W'(m_rdy));
      chk("model_oCnt", W'(oCnt), W'(sb.size()));
      chk("model_oDat", oDat, m_last);
      if (stab) begin
         chk("stable_oVld", W'(oVld), W'(1'b1));
         chk("stable_oDat", oDat, pv_dat);
      end
   endtask

   initial begin
      logic [W-1:0] ctr;
      rst = 1'b0; iClr = 1'b0; iVld = 1'b0; iRdy = 1'b0; iDat = '0;

      // Reset with upstream pushing; no capture until after release
      add(0,0,1,0,32'hA5A5A5A5, 0,0,2'd0,INI);
      add(0,0,1,0,32'hA5A5A5A5, 0,0,2'd0,INI);
      add(1,0,1,0,32'hA5A5A5A5, 0,1,2'd0,INI);
      // Streaming 1..8 with iRdy=1
      for (int i = 1; i <= 8; i++) add(1,0,1,1,W'(i), 1,1,2'd1,W'(i));
      add(1,0,0,1,32'h0, 0,1,2'd0,32'h8);
      // Back-pressure fills skid, then drains in order
      add(1,0,1,0,32'h11, 1,1,2'd1,32'h11);
      add(1,0,1,0,32'h22, 1,0,2'd2,32'h11);
      add(1,0,1,0,32'h33, 1,0,2'd2,32'h11);
      add(1,0,1,1,32'h33, 1,1,2'd1,32'h22);
      add(1,0,1,1,32'h33, 1,1,2'd1,32'h33);
      add(1,0,0,1,32'h0,  0,1,2'd0,32'h33);
      // Clear from FULL with both handshakes active
      add(1,0,1,0,32'hAA, 1,1,2'd1,32'hAA);
      add(1,0,1,0,32'hBB, 1,0,2'd2,32'hAA);
      add(1,1,1,1,32'hCC, 0,1,2'd0,INI);
      add(1,0,0,1,32'h0,  0,1,2'd0,INI);
      // Reset mid-stream while BUSY
      add(1,0,1,1,32'h44, 1,1,2'd1,32'h44);
      add(0,0,1,1,32'h55, 0,0,2'd0,INI);
      add(0,0,1,1,32'h66, 0,0,2'd0,INI);
      add(1,0,1,1,32'h77, 0,1,2'd0,INI);
      add(1,0,0,1,32'h0,  0,1,2'd0,INI);

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].rd, tbl[i].d);
         chk("vec_oVld", W'(oVld), W'(tbl[i].ev));
         chk("vec_oRdy", W'(oRdy), W'(tbl[i].er));
         chk("vec_oCnt", W'(oCnt), W'(tbl[i].ec));
         chk("vec_oDat", oDat, tbl[i].ed);
      end

      // Random stress with sparse clears and an incrementing payload
      ctr = 32'h1000;
      for (int n = 0; n < 2000; n++) begin
         logic v;
         logic rd;
         logic c;
         v  = 1'($urandom_range(0, 1));
         rd = 1'($urandom_range(0, 2) != 0);
         c  = ($urandom_range(0, 63) == 0);
         step(1'b1, c, v, rd, ctr);
         if (v && m_rdy) ctr = ctr + 1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
